// File: rtl/decoder_3r_pipe_pkg.sv
// Shared definitions for the 3R-format decode pipeline: op codes, minor
// opcodes (inst[22:15]) and the skid-buffer state encoding.
package decoder_3r_pipe_pkg;

    localparam int OP_W = 8;

    // Decoded op codes. OP_INVALID is zero so a cleared register reads invalid.
    localparam logic [OP_W-1:0] OP_INVALID = 8'h00;
    localparam logic [OP_W-1:0] OP_ADD     = 8'h01;
    localparam logic [OP_W-1:0] OP_SUB     = 8'h02;
    localparam logic [OP_W-1:0] OP_SLT     = 8'h03;
    localparam logic [OP_W-1:0] OP_SLTU    = 8'h04;
    localparam logic [OP_W-1:0] OP_NOR     = 8'h05;
    localparam logic [OP_W-1:0] OP_AND     = 8'h06;
    localparam logic [OP_W-1:0] OP_OR      = 8'h07;
    localparam logic [OP_W-1:0] OP_XOR     = 8'h08;
    localparam logic [OP_W-1:0] OP_SLL     = 8'h09;
    localparam logic [OP_W-1:0] OP_SRL     = 8'h0A;
    localparam logic [OP_W-1:0] OP_SRA     = 8'h0B;
    localparam logic [OP_W-1:0] OP_MUL     = 8'h0C;
    localparam logic [OP_W-1:0] OP_MULH    = 8'h0D;
    localparam logic [OP_W-1:0] OP_MULHU   = 8'h0E;
    localparam logic [OP_W-1:0] OP_DIV     = 8'h0F;
    localparam logic [OP_W-1:0] OP_MOD     = 8'h10;
    localparam logic [OP_W-1:0] OP_DIVU    = 8'h11;
    localparam logic [OP_W-1:0] OP_MODU    = 8'h12;
    localparam logic [OP_W-1:0] OP_BREAK   = 8'h13;
    localparam logic [OP_W-1:0] OP_SYSCALL = 8'h14;
    localparam logic [OP_W-1:0] OP_SLLI    = 8'h15;
    localparam logic [OP_W-1:0] OP_SRLI    = 8'h16;
    localparam logic [OP_W-1:0] OP_SRAI    = 8'h17;

    // Minor opcodes found in inst[22:15] when inst[31:23] is zero.
    localparam logic [7:0] MIN_ADD     = 8'h20;
    localparam logic [7:0] MIN_SUB     = 8'h22;
    localparam logic [7:0] MIN_SLT     = 8'h24;
    localparam logic [7:0] MIN_SLTU    = 8'h25;
    localparam logic [7:0] MIN_NOR     = 8'h28;
    localparam logic [7:0] MIN_AND     = 8'h29;
    localparam logic [7:0] MIN_OR      = 8'h2A;
    localparam logic [7:0] MIN_XOR     = 8'h2B;
    localparam logic [7:0] MIN_SLL     = 8'h2E;
    localparam logic [7:0] MIN_SRL     = 8'h2F;
    localparam logic [7:0] MIN_SRA     = 8'h30;
    localparam logic [7:0] MIN_MUL     = 8'h38;
    localparam logic [7:0] MIN_MULH    = 8'h39;
    localparam logic [7:0] MIN_MULHU   = 8'h3A;
    localparam logic [7:0] MIN_DIV     = 8'h40;
    localparam logic [7:0] MIN_MOD     = 8'h41;
    localparam logic [7:0] MIN_DIVU    = 8'h42;
    localparam logic [7:0] MIN_MODU    = 8'h43;
    localparam logic [7:0] MIN_BREAK   = 8'h54;
    localparam logic [7:0] MIN_SYSCALL = 8'h56;
    localparam logic [7:0] MIN_SLLI    = 8'h81;
    localparam logic [7:0] MIN_SRLI    = 8'h89;
    localparam logic [7:0] MIN_SRAI    = 8'h91;

    // Occupancy of the head/skid pair.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/decoder_3r_lane.sv
// Combinational decode of one 3R-format instruction word.
module decoder_3r_lane
    import decoder_3r_pipe_pkg::*;
(
    input  logic [31:0]     inst_i,
    input  logic            mask_i,
    output logic [OP_W-1:0] op_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rj_o,
    output logic [4:0]      rk_o,
    output logic [4:0]      ui5_o,
    output logic            invalid_o
);

    assign rd_o = inst_i[4:0];
    assign rj_o = inst_i[9:5];
    assign rk_o = inst_i[14:10];

    // Minor-opcode table lookup; masked-off lanes and non-3R words stay invalid.
    always_comb begin
        op_o = OP_INVALID;
        if (mask_i && (inst_i[31:23] == 9'd0)) begin
            case (inst_i[22:15])
                MIN_ADD:     op_o = OP_ADD;
                MIN_SUB:     op_o = OP_SUB;
                MIN_SLT:     op_o = OP_SLT;
                MIN_SLTU:    op_o = OP_SLTU;
                MIN_NOR:     op_o = OP_NOR;
                MIN_AND:     op_o = OP_AND;
                MIN_OR:      op_o = OP_OR;
                MIN_XOR:     op_o = OP_XOR;
                MIN_SLL:     op_o = OP_SLL;
                MIN_SRL:     op_o = OP_SRL;
                MIN_SRA:     op_o = OP_SRA;
                MIN_MUL:     op_o = OP_MUL;
                MIN_MULH:    op_o = OP_MULH;
                MIN_MULHU:   op_o = OP_MULHU;
                MIN_DIV:     op_o = OP_DIV;
                MIN_MOD:     op_o = OP_MOD;
                MIN_DIVU:    op_o = OP_DIVU;
                MIN_MODU:    op_o = OP_MODU;
                MIN_BREAK:   op_o = OP_BREAK;
                MIN_SYSCALL: op_o = OP_SYSCALL;
                MIN_SLLI:    op_o = OP_SLLI;
                MIN_SRLI:    op_o = OP_SRLI;
                MIN_SRAI:    op_o = OP_SRAI;
                default:     op_o = OP_INVALID;
            endcase
        end
    end

    // Invalid flag only for live lanes; ui5 only meaningful for shift-immediates.
    always_comb begin
        invalid_o = mask_i && (op_o == OP_INVALID);
        ui5_o     = 5'd0;
        if ((op_o == OP_SLLI) || (op_o == OP_SRLI) || (op_o == OP_SRAI))
            ui5_o = inst_i[14:10];
    end

endmodule

// File: rtl/decoder_3r_pipe.sv
// Registered multi-lane 3R decoder with a 2-entry skid buffer.
// in_ready is a flop, so out_ready never reaches upstream combinationally.
// Optional statistics counters: define DECODER_3R_PIPE_STAT_EN.
module decoder_3r_pipe
    import decoder_3r_pipe_pkg::*;
#(
    parameter int LANES = 1,
    parameter int OP_W  = decoder_3r_pipe_pkg::OP_W,
    parameter int PC_W  = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*32-1:0]   in_inst,
    input  logic [PC_W-1:0]       in_pc,
    input  logic [LANES-1:0]      in_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*OP_W-1:0] out_op,
    output logic [LANES*5-1:0]    out_rd,
    output logic [LANES*5-1:0]    out_rj,
    output logic [LANES*5-1:0]    out_rk,
    output logic [LANES*5-1:0]    out_ui5,
    output logic [LANES-1:0]      out_invalid,
    output logic [PC_W-1:0]       out_pc,
    output logic [LANES-1:0]      out_mask
`ifdef DECODER_3R_PIPE_STAT_EN
    ,
    output logic [31:0]           stat_decoded,
    output logic [31:0]           stat_invalid
`endif
);

    typedef struct packed {
        logic [PC_W-1:0]             pc;
        logic [LANES-1:0]            mask;
        logic [LANES-1:0]            inv;
        logic [LANES-1:0][OP_W-1:0]  op;
        logic [LANES-1:0][4:0]       rd;
        logic [LANES-1:0][4:0]       rj;
        logic [LANES-1:0][4:0]       rk;
        logic [LANES-1:0][4:0]       ui5;
    } bundle_t;

    logic [LANES-1:0][OP_W-1:0] dec_op;
    logic [LANES-1:0][4:0]      dec_rd, dec_rj, dec_rk, dec_ui5;
    logic [LANES-1:0]           dec_inv;
    bundle_t                    dec;
    bundle_t                    head_q, skid_q;
    buf_state_e                 state_q;
    logic                       in_ready_q, out_valid_q;
    logic                       in_fire, out_fire;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        decoder_3r_lane u_lane (
            .inst_i    (in_inst[32*g +: 32]),
            .mask_i    (in_mask[g]),
            .op_o      (dec_op[g]),
            .rd_o      (dec_rd[g]),
            .rj_o      (dec_rj[g]),
            .rk_o      (dec_rk[g]),
            .ui5_o     (dec_ui5[g]),
            .invalid_o (dec_inv[g])
        );
    end

    assign dec = '{pc: in_pc, mask: in_mask, inv: dec_inv, op: dec_op,
                   rd: dec_rd, rj: dec_rj, rk: dec_rk, ui5: dec_ui5};

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Buffer FSM: head drives the outputs, skid catches one bundle under backpressure.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= BUF_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_q      <= '0;
            head_q.op   <= {LANES{OP_INVALID}};
            skid_q      <= '0;
            skid_q.op   <= {LANES{OP_INVALID}};
        end else if (flush) begin
            state_q     <= BUF_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (in_fire) begin
                        head_q      <= dec;
                        out_valid_q <= 1'b1;
                        state_q     <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (in_fire && out_fire) begin
                        head_q <= dec;
                    end else if (in_fire) begin
                        skid_q     <= dec;
                        in_ready_q <= 1'b0;
                        state_q    <= BUF_TWO;
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                        state_q     <= BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    // in_ready_q is low here, so no input can arrive this cycle.
                    if (out_fire) begin
                        head_q     <= skid_q;
                        in_ready_q <= 1'b1;
                        state_q    <= BUF_ONE;
                    end
                end
                default: begin
                    state_q     <= BUF_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_op      = head_q.op;
    assign out_rd      = head_q.rd;
    assign out_rj      = head_q.rj;
    assign out_rk      = head_q.rk;
    assign out_ui5     = head_q.ui5;
    assign out_invalid = head_q.inv;
    assign out_pc      = head_q.pc;
    assign out_mask    = head_q.mask;

`ifdef DECODER_3R_PIPE_STAT_EN
    logic [31:0] stat_dec_q, stat_inv_q;
    logic [32:0] stat_dec_d, stat_inv_d;

    // Popcount of the departing head added onto each counter, one spare bit for saturation.
    always_comb begin
        stat_dec_d = {1'b0, stat_dec_q};
        stat_inv_d = {1'b0, stat_inv_q};
        for (int i = 0; i < LANES; i++) begin
            stat_dec_d = stat_dec_d + 33'(head_q.mask[i]);
            stat_inv_d = stat_inv_d + 33'(head_q.inv[i]);
        end
    end

    // Count only bundles actually handed downstream; a flush cycle kills the head.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_dec_q <= '0;
            stat_inv_q <= '0;
        end else if (out_fire && !flush) begin
            stat_dec_q <= stat_dec_d[32] ? '1 : stat_dec_d[31:0];
            stat_inv_q <= stat_inv_d[32] ? '1 : stat_inv_d[31:0];
        end
    end

    assign stat_decoded = stat_dec_q;
    assign stat_invalid = stat_inv_q;
`endif

endmodule

// File: tb/tb_decoder_3r_pipe.sv
// Bench for decoder_3r_pipe (LANES=2): vector table, handshake corner cases,
// async reset, then random traffic against a queue-based reference model.
module tb_decoder_3r_pipe;
    import decoder_3r_pipe_pkg::*;

    localparam int LANES = 2;
    localparam int PC_W  = 32;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic [1:0]  in_mask = '0;
    logic        in_ready, out_valid;
    logic [15:0] out_op;
    logic [9:0]  out_rd, out_rj, out_rk, out_ui5;
    logic [1:0]  out_invalid, out_mask;
    logic [31:0] out_pc;
`ifdef DECODER_3R_PIPE_STAT_EN
    logic [31:0] stat_decoded, stat_invalid;
    int unsigned exp_sdec = 0, exp_sinv = 0;
`endif

    decoder_3r_pipe #(.LANES(LANES), .OP_W(8), .PC_W(PC_W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_pc(in_pc), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_rd(out_rd), .out_rj(out_rj), .out_rk(out_rk), .out_ui5(out_ui5),
        .out_invalid(out_invalid), .out_pc(out_pc), .out_mask(out_mask)
`ifdef DECODER_3R_PIPE_STAT_EN
        , .stat_decoded(stat_decoded), .stat_invalid(stat_invalid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] op;
        logic [9:0]  rd, rj, rk, ui5;
        logic [1:0]  inv, mask;
        logic [31:0] pc;
    } bnd_t;

    typedef struct {
        logic [63:0] inst;
        logic [1:0]  mask;
        logic [15:0] op;
        logic [1:0]  inv;
        logic [9:0]  ui5;
    } vec_t;

    bnd_t       q[$];
    logic [7:0] op_tab [256];
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the opcode table.
    function automatic bnd_t model(input logic [63:0] inst, input logic [1:0] mask,
                                   input logic [31:0] pc);
        bnd_t b;
        logic [31:0] w;
        logic [7:0]  o;
        b.mask = mask;
        b.pc   = pc;
        b.op = '0; b.rd = '0; b.rj = '0; b.rk = '0; b.ui5 = '0; b.inv = '0;
        for (int l = 0; l < 2; l++) begin
            w = inst[32*l +: 32];
            o = OP_INVALID;
            if (mask[l] && w[31:23] == 9'd0) o = op_tab[w[22:15]];
            b.op[8*l +: 8]  = o;
            b.rd[5*l +: 5]  = w[4:0];
            b.rj[5*l +: 5]  = w[9:5];
            b.rk[5*l +: 5]  = w[14:10];
            b.ui5[5*l +: 5] = (o == OP_SLLI || o == OP_SRLI || o == OP_SRAI) ? w[14:10] : 5'd0;
            b.inv[l]        = mask[l] && (o == OP_INVALID);
        end
        return b;
    endfunction

    task automatic check_outputs();
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) begin
            chk("op", out_op, q[0].op);
            chk("rd", out_rd, q[0].rd);
            chk("rj", out_rj, q[0].rj);
            chk("rk", out_rk, q[0].rk);
            chk("ui5", out_ui5, q[0].ui5);
            chk("invalid", out_invalid, q[0].inv);
            chk("pc", out_pc, q[0].pc);
            chk("mask", out_mask, q[0].mask);
        end
`ifdef DECODER_3R_PIPE_STAT_EN
        chk("stat_decoded", stat_decoded, exp_sdec);
        chk("stat_invalid", stat_invalid, exp_sinv);
`endif
    endtask

    // One clock: predict transfers from current inputs, update the model, check outputs.
    task automatic tick();
        bit acc, pop;
        acc = in_valid && (q.size() < 2) && !flush;
        pop = (q.size() > 0) && out_ready && !flush;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (pop) begin
`ifdef DECODER_3R_PIPE_STAT_EN
                exp_sdec += $countones(q[0].mask);
                exp_sinv += $countones(q[0].inv);
`endif
                void'(q.pop_front());
            end
            if (acc) q.push_back(model(in_inst, in_mask, in_pc));
        end
        #1;
        check_outputs();
    endtask

    task automatic send(input logic [31:0] w1, input logic [31:0] w0, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = {w1, w0};
        in_mask  = 2'b11;
        in_pc    = pc;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [7:0] mins [23];
        int r;
        mins = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2E, 8'h2F,
                 8'h30, 8'h38, 8'h39, 8'h3A, 8'h40, 8'h41, 8'h42, 8'h43, 8'h54, 8'h56,
                 8'h81, 8'h89, 8'h91};
        r = $urandom_range(0, 9);
        if (r < 6) return {9'd0, mins[$urandom_range(0, 22)], 15'($urandom)};
        if (r < 8) return {9'd0, 8'($urandom), 15'($urandom)};
        return $urandom;
    endfunction

    vec_t vt [8];

    initial begin
        for (int i = 0; i < 256; i++) op_tab[i] = OP_INVALID;
        op_tab[8'h20] = OP_ADD;   op_tab[8'h22] = OP_SUB;   op_tab[8'h24] = OP_SLT;
        op_tab[8'h25] = OP_SLTU;  op_tab[8'h28] = OP_NOR;   op_tab[8'h29] = OP_AND;
        op_tab[8'h2A] = OP_OR;    op_tab[8'h2B] = OP_XOR;   op_tab[8'h2E] = OP_SLL;
        op_tab[8'h2F] = OP_SRL;   op_tab[8'h30] = OP_SRA;   op_tab[8'h38] = OP_MUL;
        op_tab[8'h39] = OP_MULH;  op_tab[8'h3A] = OP_MULHU; op_tab[8'h40] = OP_DIV;
        op_tab[8'h41] = OP_MOD;   op_tab[8'h42] = OP_DIVU;  op_tab[8'h43] = OP_MODU;
        op_tab[8'h54] = OP_BREAK; op_tab[8'h56] = OP_SYSCALL;
        op_tab[8'h81] = OP_SLLI;  op_tab[8'h89] = OP_SRLI;  op_tab[8'h91] = OP_SRAI;

        // Lane 1 in the upper word. 0x00101C83 carries minor 0x20, so it is ADD.
        vt[0] = '{64'h00101C83_00150C41, 2'b11, {OP_ADD, OP_OR}, 2'b00, 10'd0};
        vt[1] = '{64'h00100C41_0048FC21, 2'b11, {OP_ADD, OP_SRAI}, 2'b00, {5'd0, 5'd31}};
        vt[2] = '{64'h02800000_00000000, 2'b11, {OP_INVALID, OP_INVALID}, 2'b11, 10'd0};
        vt[3] = '{64'h02800000_00000000, 2'b00, {OP_INVALID, OP_INVALID}, 2'b00, 10'd0};
        vt[4] = '{64'h002B0000_002A0000, 2'b11, {OP_SYSCALL, OP_BREAK}, 2'b00, 10'd0};
        vt[5] = '{64'h0044C400_00409400, 2'b11, {OP_SRLI, OP_SLLI}, 2'b00, {5'd17, 5'd5}};
        vt[6] = '{64'h00108000_00218000, 2'b11, {OP_INVALID, OP_MODU}, 2'b10, 10'd0};
        vt[7] = '{64'h00100C41_00110000, 2'b01, {OP_INVALID, OP_SUB}, 2'b00, 10'd0};

        // Reset state, observed while reset is still asserted.
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_op", out_op, {OP_INVALID, OP_INVALID});
        chk("rst_rd", out_rd, 10'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_mask", out_mask, 2'd0);
        resetn = 1'b1;

        // Table vectors, streaming with out_ready high.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_inst  = vt[i].inst;
            in_mask  = vt[i].mask;
            in_pc    = 32'h1000 + 32'(i * 8);
            tick();
            chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("vec%0d_op", i), out_op, vt[i].op);
            chk($sformatf("vec%0d_inv", i), out_invalid, vt[i].inv);
            chk($sformatf("vec%0d_ui5", i), out_ui5, vt[i].ui5);
            if (i == 0) begin
                chk("vec0_rd", out_rd, {5'd3, 5'd1});
                chk("vec0_rj", out_rj, {5'd4, 5'd2});
                chk("vec0_rk", out_rk, {5'd7, 5'd3});
            end
            if (i == 1) begin
                chk("vec1_rd", out_rd, {5'd1, 5'd1});
                chk("vec1_rj", out_rj[4:0], 5'd1);
            end
        end
        in_valid = 1'b0;
        tick();

        // Backpressure: A, B accepted, C waits; release drains in order.
        out_ready = 1'b0;
        send(32'h00100C41, 32'h00150C41, 32'h100); tick();
        chk("bp_a_ready", in_ready, 1'b1);
        send(32'h00110000, 32'h0048FC21, 32'h200); tick();
        chk("bp_b_ready", in_ready, 1'b0);
        send(32'h002A0000, 32'h00101C83, 32'h300); tick();
        chk("bp_hold_pc1", out_pc, 32'h100);
        tick();
        chk("bp_hold_pc2", out_pc, 32'h100);
        chk("bp_hold_op", out_op, {OP_ADD, OP_OR});
        out_ready = 1'b1; tick();
        chk("bp_b_pc", out_pc, 32'h200);
        chk("bp_ready_back", in_ready, 1'b1);
        tick();
        chk("bp_c_pc", out_pc, 32'h300);
        in_valid = 1'b0; tick();
        chk("bp_drained", out_valid, 1'b0);

        // Flush in TWO with in_valid high.
        out_ready = 1'b0;
        send(32'h00100C41, 32'h00100C41, 32'h400); tick();
        send(32'h00100C41, 32'h00100C41, 32'h500); tick();
        flush = 1'b1;
        send(32'h00100C41, 32'h00100C41, 32'h600); tick();
        chk("fl2_valid", out_valid, 1'b0);
        chk("fl2_ready", in_ready, 1'b1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("fl2_quiet", out_valid, 1'b0);

        // Flush in ONE with a same-cycle in_fire: the incoming bundle is dropped.
        send(32'h00100C41, 32'h00100C41, 32'h700); tick();
        flush = 1'b1;
        send(32'h00110000, 32'h00110000, 32'h800); tick();
        chk("fl1_valid", out_valid, 1'b0);
        flush = 1'b0; in_valid = 1'b0; tick();
        chk("fl1_quiet", out_valid, 1'b0);

        // Async reset between edges while holding two bundles.
        out_ready = 1'b0;
        send(32'h00100C41, 32'h0048FC21, 32'h900); tick();
        send(32'h00100C41, 32'h0048FC21, 32'hA00); tick();
        in_valid = 1'b0;
        #3;
        resetn = 1'b0;
        #1;
        q.delete();
`ifdef DECODER_3R_PIPE_STAT_EN
        exp_sdec = 0; exp_sinv = 0;
        chk("ar_stat_dec", stat_decoded, 32'd0);
        chk("ar_stat_inv", stat_invalid, 32'd0);
`endif
        chk("ar_valid", out_valid, 1'b0);
        chk("ar_ready", in_ready, 1'b1);
        chk("ar_op", out_op, {OP_INVALID, OP_INVALID});
        chk("ar_pc", out_pc, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        out_ready = 1'b1;
        send(32'h00100C41, 32'h00150C41, 32'hB00); tick();
        chk("ar_restart_pc", out_pc, 32'hB00);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_inst   = {rand_inst(), rand_inst()};
            in_mask   = 2'($urandom);
            in_pc     = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
